// File: rtl/bp_pkg.sv
// Shared types and counter helpers for the branch predictor (BHT + BTB).
package bp_pkg;

   localparam int unsigned BP_PC_W_MAX  = 32;
   localparam int unsigned BP_TAG_W_MAX = 32;
   localparam int unsigned BP_CNT_W_MAX = 8;

   typedef logic [BP_CNT_W_MAX-1:0] bp_cnt_t;

   typedef struct packed {
      logic                    valid;
      logic [BP_TAG_W_MAX-1:0] tag;
      bp_cnt_t                 cnt;
      logic [BP_PC_W_MAX-1:0]  target;
   } bp_entry_t;

   function automatic bp_cnt_t cnt_max(input int unsigned cnt_w);
      return bp_cnt_t'((1 << cnt_w) - 1);
   endfunction

   function automatic bp_cnt_t weak_taken(input int unsigned cnt_w);
      return bp_cnt_t'(1 << (cnt_w - 1));
   endfunction

   function automatic bp_cnt_t weak_not_taken(input int unsigned cnt_w);
      return bp_cnt_t'((1 << (cnt_w - 1)) - 1);
   endfunction

   function automatic bp_cnt_t sat_inc(input bp_cnt_t c, input bp_cnt_t maxv);
      return (c >= maxv) ? maxv : c + bp_cnt_t'(1);
   endfunction

   function automatic bp_cnt_t sat_dec(input bp_cnt_t c);
      return (c == '0) ? '0 : c - bp_cnt_t'(1);
   endfunction

endpackage

// File: rtl/bht_btb_predictor_sat_counter_update.sv
// Next-counter value for one table entry: allocate to weak state, else saturate up/down.
module sat_counter_update
   import bp_pkg::*;
#(
   parameter int unsigned CNT_W = 2
) (
   input  bp_cnt_t i_cnt,
   input  logic    i_taken,
   input  logic    i_alloc,
   output bp_cnt_t o_cnt_c
);

   localparam bp_cnt_t CNT_MAX = cnt_max(CNT_W);
   localparam bp_cnt_t CNT_WT  = weak_taken(CNT_W);
   localparam bp_cnt_t CNT_WNT = weak_not_taken(CNT_W);

   always_comb begin
      o_cnt_c = i_cnt;
      if (i_alloc) begin
         o_cnt_c = i_taken ? CNT_WT : CNT_WNT;
      end else if (i_taken) begin
         o_cnt_c = sat_inc(i_cnt, CNT_MAX);
      end else begin
         o_cnt_c = sat_dec(i_cnt);
      end
   end

endmodule

// File: rtl/bht_btb_predictor.sv
// Direct-mapped branch history + target table, looked up from Fetch, trained from Execute.
// Optional global-history (gshare) indexing is enabled with `define BP_GSHARE_EN.
module bht_btb_predictor
   import bp_pkg::*;
#(
   parameter int unsigned ENTRIES = 16,
   parameter int unsigned CNT_W   = 2,
   parameter int unsigned GHR_W   = 4,
   parameter int unsigned PC_W    = 32
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [PC_W-1:0]              PCF,
   output logic                         Predict_branchF,
   output logic [PC_W-1:0]              Target_finalF,
   output logic [$clog2(ENTRIES)-1:0]   IndexF,
   input  logic                         Eval_branch,
   input  logic [PC_W-1:0]              PCE,
   input  logic [$clog2(ENTRIES)-1:0]   IndexE,
   input  logic                         PCSrcE,
   input  logic [PC_W-1:0]              PCTargetE,
   input  logic                         Predict_branchE,
   output logic                         Prediction_Correct,
   output logic [31:0]                  BranchCount,
   output logic [31:0]                  MispredCount
);

   localparam int unsigned IDX_W = $clog2(ENTRIES);
   localparam bp_entry_t RST_ENTRY = '{valid: 1'b0, tag: '0,
                                       cnt: weak_not_taken(CNT_W), target: '0};

   bp_entry_t   r_table [ENTRIES];
   logic [31:0] r_branch_cnt;
   logic [31:0] r_mispred_cnt;

   logic [IDX_W-1:0] w_idx_f;
   bp_entry_t        w_entry_f;
   bp_entry_t        w_entry_e;
   bp_entry_t        w_new_entry;
   logic             w_hit_f;
   logic             w_hit_e;
   bp_cnt_t          w_cnt_next;
   logic             w_unused;

`ifdef BP_GSHARE_EN
   logic [GHR_W-1:0] r_ghr;

   // History shifts in each resolved outcome; dropping the top bit via truncation
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ghr <= '0;
      end else if (Eval_branch) begin
         r_ghr <= GHR_W'({r_ghr, PCSrcE});
      end
   end

   assign w_idx_f  = PCF[IDX_W+1:2] ^ IDX_W'(r_ghr);
   assign w_unused = &{1'b0, PCE[IDX_W+1:0]};
`else
   assign w_idx_f  = PCF[IDX_W+1:2];
   assign w_unused = &{1'b0, PCE[IDX_W+1:0], GHR_W[0]};
`endif

   // Fetch-side lookup
   assign w_entry_f       = r_table[w_idx_f];
   assign w_hit_f         = w_entry_f.valid
                            && (w_entry_f.tag == BP_TAG_W_MAX'(PCF[PC_W-1:IDX_W+2]));
   assign Predict_branchF = w_hit_f && w_entry_f.cnt[CNT_W-1];
   assign Target_finalF   = Predict_branchF ? PC_W'(w_entry_f.target) : PCF + PC_W'(4);
   assign IndexF          = w_idx_f;

   assign Prediction_Correct = !Eval_branch || (Predict_branchE == PCSrcE);

   // Execute-side training: hit updates in place, miss reallocates the entry
   assign w_entry_e = r_table[IndexE];
   assign w_hit_e   = w_entry_e.valid
                      && (w_entry_e.tag == BP_TAG_W_MAX'(PCE[PC_W-1:IDX_W+2]));

   sat_counter_update #(
      .CNT_W (CNT_W)
   ) u_cnt_upd (
      .i_cnt   (w_entry_e.cnt),
      .i_taken (PCSrcE),
      .i_alloc (!w_hit_e),
      .o_cnt_c (w_cnt_next)
   );

   always_comb begin
      w_new_entry        = w_entry_e;
      w_new_entry.valid  = 1'b1;
      w_new_entry.tag    = BP_TAG_W_MAX'(PCE[PC_W-1:IDX_W+2]);
      w_new_entry.cnt    = w_cnt_next;
      if (!w_hit_e || PCSrcE) begin
         w_new_entry.target = BP_PC_W_MAX'(PCTargetE);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            r_table[IDX_W'(i)] <= RST_ENTRY;
         end
         r_branch_cnt  <= '0;
         r_mispred_cnt <= '0;
      end else if (Eval_branch) begin
         r_table[IndexE] <= w_new_entry;
         if (r_branch_cnt != '1) begin
            r_branch_cnt <= r_branch_cnt + 32'd1;
         end
         if (!Prediction_Correct && (r_mispred_cnt != '1)) begin
            r_mispred_cnt <= r_mispred_cnt + 32'd1;
         end
      end
   end

   assign BranchCount  = r_branch_cnt;
   assign MispredCount = r_mispred_cnt;

endmodule

// File: tb/tb_bht_btb_predictor.sv
// Self-checking bench for bht_btb_predictor: directed vector table plus randomized model check.
module tb_bht_btb_predictor;

   localparam int unsigned ENT = 16;
   localparam int unsigned IW  = 4;
   localparam int unsigned CW  = 2;
   localparam int unsigned GW  = 4;
   localparam int unsigned PW  = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic [PW-1:0] pcf;
   logic          pred_f;
   logic [PW-1:0] tgt_f;
   logic [IW-1:0] idx_f;
   logic          eval;
   logic [PW-1:0] pce;
   logic [IW-1:0] idx_e;
   logic          taken;
   logic [PW-1:0] ptgt;
   logic          pred_e;
   logic          ok;
   logic [31:0]   bcnt;
   logic [31:0]   mcnt;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   bht_btb_predictor #(.ENTRIES(ENT), .CNT_W(CW), .GHR_W(GW), .PC_W(PW)) dut (
      .clk                (clk),
      .rst                (rst),
      .PCF                (pcf),
      .Predict_branchF    (pred_f),
      .Target_finalF      (tgt_f),
      .IndexF             (idx_f),
      .Eval_branch        (eval),
      .PCE                (pce),
      .IndexE             (idx_e),
      .PCSrcE             (taken),
      .PCTargetE          (ptgt),
      .Predict_branchE    (pred_e),
      .Prediction_Correct (ok),
      .BranchCount        (bcnt),
      .MispredCount       (mcnt)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic        rst;
      logic        eval;
      logic [31:0] pcf;
      logic [31:0] pce;
      logic        taken;
      logic [31:0] ptgt;
      logic        prede;
      logic        exp_pred;
      logic [31:0] exp_tgt;
      logic        exp_ok;
      int          exp_bc;
      int          exp_mc;
   } vec_t;

   function automatic vec_t mk(input logic r, input logic e, input logic [31:0] f,
                               input logic [31:0] p, input logic t, input logic [31:0] g,
                               input logic pe, input logic xp, input logic [31:0] xt,
                               input logic xo, input int xb, input int xm);
      vec_t v;
      v.rst = r; v.eval = e; v.pcf = f; v.pce = p; v.taken = t; v.ptgt = g; v.prede = pe;
      v.exp_pred = xp; v.exp_tgt = xt; v.exp_ok = xo; v.exp_bc = xb; v.exp_mc = xm;
      return v;
   endfunction

   // Reference model: plain integer table driven straight from the behavioural rules
   bit          m_valid [ENT];
   int unsigned m_tag   [ENT];
   int          m_cnt   [ENT];
   logic [31:0] m_tgt   [ENT];
   longint      m_bc, m_mc;
   int unsigned m_ghr;

   localparam int WNT  = (1 << (CW - 1)) - 1;
   localparam int WT   = 1 << (CW - 1);
   localparam int CMAX = (1 << CW) - 1;

   task automatic m_reset();
      for (int i = 0; i < ENT; i++) begin
         m_valid[i] = 1'b0; m_tag[i] = 0; m_cnt[i] = WNT; m_tgt[i] = '0;
      end
      m_bc = 0; m_mc = 0; m_ghr = 0;
   endtask

   function automatic int unsigned m_index(input logic [31:0] pc);
      int unsigned ix;
      ix = (pc >> 2) % ENT;
`ifdef BP_GSHARE_EN
      ix = ix ^ m_ghr;
`endif
      return ix;
   endfunction

   task automatic m_update(input int unsigned ix, input logic [31:0] p, input logic t,
                           input logic [31:0] g, input logic correct);
      if (m_bc < 64'hFFFF_FFFF) m_bc++;
      if (!correct && m_mc < 64'hFFFF_FFFF) m_mc++;
      if (m_valid[ix] && m_tag[ix] == (p >> (IW + 2))) begin
         m_cnt[ix] = t ? ((m_cnt[ix] < CMAX) ? m_cnt[ix] + 1 : CMAX)
                       : ((m_cnt[ix] > 0) ? m_cnt[ix] - 1 : 0);
         if (t) m_tgt[ix] = g;
      end else begin
         m_valid[ix] = 1'b1;
         m_tag[ix]   = p >> (IW + 2);
         m_cnt[ix]   = t ? WT : WNT;
         m_tgt[ix]   = g;
      end
      m_ghr = ((m_ghr << 1) | 32'(t)) % (1 << GW);
   endtask

   task automatic drive(input logic r, input logic e, input logic [31:0] f, input logic [31:0] p,
                        input logic [IW-1:0] ie, input logic t, input logic [31:0] g,
                        input logic pe);
      rst = r; eval = e; pcf = f; pce = p; idx_e = ie; taken = t; ptgt = g; pred_e = pe;
   endtask

   vec_t vt[$];

   initial begin
      drive(1'b1, 1'b0, 32'h0, 32'h0, '0, 1'b0, 32'h0, 1'b0);
      repeat (2) @(posedge clk);

`ifndef BP_GSHARE_EN
      //       rst eval pcf     pce     tk  ptgt    pE  xPred xTgt    xOk bc mc
      vt.push_back(mk(0, 0, 32'h100, 32'h000, 0, 32'h000, 0, 0, 32'h104, 1, 0, 0));
      vt.push_back(mk(0, 1, 32'h100, 32'h100, 1, 32'h080, 0, 0, 32'h104, 0, 0, 0));
      vt.push_back(mk(0, 1, 32'h100, 32'h100, 1, 32'h080, 1, 1, 32'h080, 1, 1, 1));
      vt.push_back(mk(0, 1, 32'h100, 32'h100, 1, 32'h080, 1, 1, 32'h080, 1, 2, 1));
      vt.push_back(mk(0, 1, 32'h100, 32'h100, 1, 32'h080, 1, 1, 32'h080, 1, 3, 1));
      vt.push_back(mk(0, 1, 32'h100, 32'h100, 0, 32'h080, 1, 1, 32'h080, 0, 4, 1));
      vt.push_back(mk(0, 0, 32'h100, 32'h000, 0, 32'h000, 0, 1, 32'h080, 1, 5, 2));
      vt.push_back(mk(0, 1, 32'h100, 32'h100, 0, 32'h080, 1, 1, 32'h080, 0, 5, 2));
      vt.push_back(mk(0, 0, 32'h100, 32'h000, 0, 32'h000, 0, 0, 32'h104, 1, 6, 3));
      vt.push_back(mk(0, 1, 32'h100, 32'h100, 1, 32'h080, 0, 0, 32'h104, 0, 6, 3));
      vt.push_back(mk(0, 0, 32'h100, 32'h000, 0, 32'h000, 0, 1, 32'h080, 1, 7, 4));
      vt.push_back(mk(0, 1, 32'h100, 32'h140, 0, 32'h200, 1, 1, 32'h080, 0, 7, 4));
      vt.push_back(mk(0, 0, 32'h100, 32'h000, 0, 32'h000, 0, 0, 32'h104, 1, 8, 5));
      vt.push_back(mk(0, 0, 32'h140, 32'h000, 0, 32'h000, 0, 0, 32'h144, 1, 8, 5));
      vt.push_back(mk(0, 1, 32'h140, 32'h140, 1, 32'h300, 0, 0, 32'h144, 0, 8, 5));
      vt.push_back(mk(0, 0, 32'h140, 32'h000, 0, 32'h000, 0, 1, 32'h300, 1, 9, 6));
      vt.push_back(mk(1, 1, 32'h140, 32'h140, 0, 32'h000, 1, 1, 32'h300, 0, 9, 6));
      vt.push_back(mk(0, 0, 32'h140, 32'h000, 0, 32'h000, 0, 0, 32'h144, 1, 0, 0));

      foreach (vt[k]) begin
         logic [31:0] pc_tmp;
         @(negedge clk);
         pc_tmp = vt[k].pce;
         drive(vt[k].rst, vt[k].eval, vt[k].pcf, vt[k].pce, pc_tmp[IW+1:2],
               vt[k].taken, vt[k].ptgt, vt[k].prede);
         #1;
         pc_tmp = vt[k].pcf;
         chk($sformatf("vec%0d pred", k),  32'(pred_f), 32'(vt[k].exp_pred));
         chk($sformatf("vec%0d tgt", k),   tgt_f,       vt[k].exp_tgt);
         chk($sformatf("vec%0d idx", k),   32'(idx_f),  32'(pc_tmp[IW+1:2]));
         chk($sformatf("vec%0d ok", k),    32'(ok),     32'(vt[k].exp_ok));
         chk($sformatf("vec%0d bcnt", k),  bcnt,        32'(vt[k].exp_bc));
         chk($sformatf("vec%0d mcnt", k),  mcnt,        32'(vt[k].exp_mc));
      end
`else
      // Outcomes T,T,N,T shift into history; fetch index becomes PC index ^ 4'b1101
      begin
         logic [3:0] outs;
         outs = 4'b1011;
         @(negedge clk);
         drive(1'b0, 1'b0, 32'h100, 32'h0, '0, 1'b0, 32'h0, 1'b0);
         #1;
         chk("gshare idx reset", 32'(idx_f), 32'd0);
         for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(1'b0, 1'b1, 32'h200, 32'h100, '0, outs[k], 32'h80, 1'b0);
         end
         @(negedge clk);
         drive(1'b0, 1'b0, 32'h100, 32'h0, '0, 1'b0, 32'h0, 1'b0);
         #1;
         chk("gshare idx after TTNT", 32'(idx_f), 32'd13);
         chk("gshare bcnt", bcnt, 32'd4);
         @(negedge clk);
         drive(1'b1, 1'b1, 32'h100, 32'h100, '0, 1'b1, 32'h0, 1'b0);
         @(negedge clk);
         drive(1'b0, 1'b0, 32'h100, 32'h0, '0, 1'b0, 32'h0, 1'b0);
         #1;
         chk("gshare idx after reset", 32'(idx_f), 32'd0);
      end
`endif

      // Randomized phase from a fresh reset, checked against the model
      @(negedge clk);
      drive(1'b1, 1'b0, 32'h0, 32'h0, '0, 1'b0, 32'h0, 1'b0);
      m_reset();
      for (int n = 0; n < 400; n++) begin
         logic [31:0] r_pcf, r_pce, r_tgt;
         logic        r_rst, r_ev, r_tk, r_pe, r_exp_pred, r_exp_ok;
         logic [31:0] r_exp_tgt;
         int unsigned ix_f, ix_e;
         @(negedge clk);
         r_rst = ($urandom_range(0, 79) == 0);
         r_ev  = ($urandom_range(0, 3) != 0);
         r_pce = 32'h1000 + ($urandom_range(0, 63) << 2);
         r_pcf = ($urandom_range(0, 3) == 0) ? r_pce : 32'h1000 + ($urandom_range(0, 63) << 2);
         r_tk  = 1'($urandom_range(0, 1));
         r_pe  = 1'($urandom_range(0, 1));
         r_tgt = $urandom_range(0, 32'h3FFF) << 2;
         ix_e  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, ENT - 1) : (r_pce >> 2) % ENT;
         drive(r_rst, r_ev, r_pcf, r_pce, IW'(ix_e), r_tk, r_tgt, r_pe);
         #1;
         ix_f       = m_index(r_pcf);
         r_exp_pred = m_valid[ix_f] && (m_tag[ix_f] == (r_pcf >> (IW + 2))) && (m_cnt[ix_f] >= WT);
         r_exp_tgt  = r_exp_pred ? m_tgt[ix_f] : r_pcf + 32'd4;
         r_exp_ok   = !r_ev || (r_pe == r_tk);
         chk("rnd pred", 32'(pred_f), 32'(r_exp_pred));
         chk("rnd tgt",  tgt_f,       r_exp_tgt);
         chk("rnd idx",  32'(idx_f),  ix_f);
         chk("rnd ok",   32'(ok),     32'(r_exp_ok));
         chk("rnd bcnt", bcnt,        32'(m_bc));
         chk("rnd mcnt", mcnt,        32'(m_mc));
         if (r_rst) m_reset();
         else if (r_ev) m_update(ix_e, r_pce, r_tk, r_tgt, r_exp_ok);
      end

      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/bht_btb_predictor.md
# bht_btb_predictor

Parametrised branch predictor for the pipelined RISC-V core: a direct-mapped table of saturating counters plus branch-target entries. It is looked up combinationally in Fetch with `PCF` and trained from Execute when a branch or `jal` resolves. It generalises the single 2-bit-state predictor in the fetch stage to N indexed entries with tags, stored targets, configurable counter width, mispredict detection and performance counters.

## Interface
Parameters:
- `ENTRIES`, default 16: table depth; power of two, at least 2. `IDX_W = $clog2(ENTRIES)`.
- `CNT_W`, default 2: saturating counter width, at least 1.
- `GHR_W`, default 4: global history width; used only with `BP_GSHARE_EN`; must satisfy `GHR_W <= IDX_W`.
- `PC_W`, default 32: program counter width.

Ports (`name direction width meaning`):
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `PCF` in PC_W: fetch PC.
- `Predict_branchF` out 1: predict taken for `PCF`.
- `Target_finalF` out PC_W: predicted next PC. Equals the stored target when `Predict_branchF` is 1, else `PCF+4`.
- `IndexF` out IDX_W: table index used for `PCF`; the pipeline carries it to Execute.
- `Eval_branch` in 1: Execute holds a resolved conditional branch or `jal` (never `jalr`); an update is requested this cycle.
- `PCE` in PC_W: PC of the resolving instruction.
- `IndexE` in IDX_W: `IndexF` as carried through the pipeline.
- `PCSrcE` in 1: actual outcome (1 = taken).
- `PCTargetE` in PC_W: actual taken target.
- `Predict_branchE` in 1: `Predict_branchF` as carried through the pipeline.
- `Prediction_Correct` out 1: combinational; `!Eval_branch | (Predict_branchE == PCSrcE)`.
- `BranchCount` out 32: number of updates performed.
- `MispredCount` out 32: number of updates with `Prediction_Correct` = 0.

## Operation
- Each entry holds `valid`, `tag` (the `PC_W-IDX_W-2` bits above the index field of the PC), a counter of `CNT_W` bits, and a target of `PC_W` bits.
- Lookup, all combinational from the registered table:
  - index = `PCF[IDX_W+1:2]`;
  - hit = `valid` and tag match;
  - `Predict_branchF` = hit and counter MSB = 1.
- Update on `Eval_branch`, applied to entry `IndexE`:
  - Tag match with `PCE`:
    - counter +1 if `PCSrcE`, else -1, saturating at 0 and at `2^CNT_W-1`;
    - target is overwritten with `PCTargetE` when `PCSrcE`.
  - Miss (invalid entry or tag mismatch): allocate the entry:
    - `valid`=1, tag from `PCE`, target=`PCTargetE`;
    - counter = `2^(CNT_W-1)` (weakly taken) if `PCSrcE`, else `2^(CNT_W-1)-1` (weakly not-taken).
  - With `CNT_W`=1, weakly not-taken is 0 and weakly taken is 1.
- Statistics:
  - `BranchCount` increments on every update.
  - `MispredCount` increments on every update with `Prediction_Correct` = 0.
  - Both saturate at `32'hFFFF_FFFF` and never wrap.
- Reset: every `valid`=0, counters = weakly not-taken, targets = 0, both statistics counters = 0, GHR = 0. Consequently `Predict_branchF`=0 and `Target_finalF`=`PCF+4`.

## Timing
- Prediction has zero-cycle latency: outputs are combinational from `PCF` within the same cycle.
- The table is written on the rising edge of `clk` in the cycle where `Eval_branch`=1.
- Same-cycle update and lookup to the same index: the lookup sees the pre-update value; the new value is visible from the next cycle.
- `rst` takes priority over a simultaneous `Eval_branch`. A reset asserted mid-stream discards that cycle's update.
- There is no stall input. A stalled Fetch simply holds `PCF`, and the outputs stay stable as long as the table is unchanged.
- `Eval_branch` may be high on consecutive cycles. Each such cycle performs an independent update.

## Configuration
- `BP_GSHARE_EN` defined: adds a `GHR_W`-bit global history register.
  - index = `PCF[IDX_W+1:2] ^ {{(IDX_W-GHR_W){1'b0}}, GHR}`.
  - On each update, GHR = `{GHR[GHR_W-2:0], PCSrcE}`; with `GHR_W`=1, GHR = `PCSrcE`.
  - The tag remains the PC bits above `[IDX_W+1:2]`.
  - Updates always use `IndexE`, never a recomputed index.
- `BP_GSHARE_EN` undefined: no GHR is implemented; the index is the PC bits only.

## Structure
- Shared package `bp_pkg`:
  - entry struct typedef (`valid`, `tag`, `cnt`, `target`);
  - functions `sat_inc` / `sat_dec`;
  - constants for weakly-taken and weakly-not-taken given `CNT_W`.
- One sub-module, `sat_counter_update`: a combinational next-counter computation from current value, taken, and allocate.
- Table storage is flop-based (asynchronous read); no SRAM macro.

## Test plan
- Reset release, `PCF`=0x100 → `Predict_branchF`=0, `Target_finalF`=0x104, both counts 0.
- Cold-miss taken branch at `PCE`=0x100, `PCTargetE`=0x80, `Predict_branchE`=0 → `Prediction_Correct`=0, `MispredCount`=1. Next cycle, `PCF`=0x100 → `Predict_branchF`=1, `Target_finalF`=0x80.
- Same branch: taken ×3, then not-taken ×1 (`CNT_W`=2) → counter 3 then 2; prediction stays taken. A second not-taken → counter 1; `PCF`=0x100 predicts not-taken.
- Alias: `ENTRIES`=16, train 0x100 taken; then update with `PCE`=0x140 not-taken → entry reallocated. `PCF`=0x100 → tag miss, `Predict_branchF`=0.
- Same-cycle `Eval_branch` on `IndexE` = `IndexF` → `Predict_branchF` reflects the old entry that cycle and the new entry the next cycle. `rst` together with `Eval_branch` → table cleared, no update.
- `BP_GSHARE_EN`, `GHR_W`=4: outcomes T,T,N,T → GHR = 4'b1101. `PCF`=0x100 → `IndexF` = 0 ^ 4'b1101 = 13.
